// File: rtl/spi_slave_ram_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_slave_ram_if                                             |
// | Description : SPI slave bridging a serial master to a single-port memory.  |
// |               Every frame is a 2-bit command followed by PAYLOAD_W bits.   |
// |               One clk edge carries one serial bit.                         |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               ss_n, mosi        - serial select / data in                  |
// |               miso              - registered serial data out               |
// |               rx_data, rx_valid - {cmd, payload} strobe to memory          |
// |               tx_data, tx_valid - read data returned by memory             |
// |               err_rd_seq        - read-data without prior read-address     |
// |               err_tx_timeout    - memory did not answer in TX_TIMEOUT      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_slave_ram_if #(
  parameter int PAYLOAD_W  = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int TX_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [PAYLOAD_W+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [PAYLOAD_W-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 err_rd_seq,
  output logic                 err_tx_timeout
);

  localparam int FRAME_W    = PAYLOAD_W + 2;
  localparam int c_CNT_W    = $clog2(FRAME_W);
  localparam int c_TX_IDX_W = $clog2(PAYLOAD_W);
  localparam int c_TMO_W    = $clog2(TX_TIMEOUT + 1);

  localparam logic [c_CNT_W-1:0] c_RX_LAST  = c_CNT_W'(FRAME_W - 1);
  localparam logic [c_CNT_W-1:0] c_TX_LAST  = c_CNT_W'(PAYLOAD_W - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TX_TIMEOUT - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
  localparam logic [1:0]         c_CMD_RADDR = 2'b10;
  localparam logic [1:0]         c_CMD_RDATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RECV    = 3'd1,
    S_WAIT_TX = 3'd2,
    S_SEND    = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t                 r_state,  w_state_nxt;
  logic [c_CNT_W-1:0]     r_cnt,    w_cnt_nxt;
  logic [c_TMO_W-1:0]     r_tmo,    w_tmo_nxt;
  logic [FRAME_W-1:0]     r_shift,  w_shift_nxt;
  logic [PAYLOAD_W-1:0]   r_tx,     w_tx_nxt;
  logic                   r_raddr_done, w_raddr_done_nxt;
  logic                   r_miso,   w_miso_nxt;
  logic [FRAME_W-1:0]     r_rx_data, w_rx_data_nxt;
  logic                   r_rx_valid, w_rx_valid_nxt;
  logic                   r_err_rd,  w_err_rd_nxt;
  logic                   r_err_tmo, w_err_tmo_nxt;

  // Frame as it will look once the bit on mosi this edge is inserted.
  int                     w_rx_ord;
  logic [c_CNT_W-1:0]     w_rx_pos;
  logic [FRAME_W-1:0]     w_frame;
  logic [1:0]             w_cmd;
  // Serial order of the next miso bit and its position in the data word.
  int                     w_tx_ord;
  logic [c_TX_IDX_W-1:0]  w_tx_pos;

  always_comb begin
    w_rx_ord = int'(r_cnt);
    // Command bits always land at the top; payload direction follows MSB_FIRST.
    if (MSB_FIRST || w_rx_ord < 2) begin
      w_rx_pos = c_CNT_W'(FRAME_W - 1 - w_rx_ord);
    end else begin
      w_rx_pos = c_CNT_W'(w_rx_ord - 2);
    end
    w_frame           = r_shift;
    w_frame[w_rx_pos] = mosi;
    w_cmd             = w_frame[FRAME_W-1 -: 2];

    // Capture edge presents serial bit 0; each SEND edge presents the next.
    if (r_state == S_SEND && int'(r_cnt) < PAYLOAD_W - 1) begin
      w_tx_ord = int'(r_cnt) + 1;
    end else begin
      w_tx_ord = 0;
    end
    if (MSB_FIRST) begin
      w_tx_pos = c_TX_IDX_W'(PAYLOAD_W - 1 - w_tx_ord);
    end else begin
      w_tx_pos = c_TX_IDX_W'(w_tx_ord);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_tmo_nxt        = r_tmo;
    w_shift_nxt      = r_shift;
    w_tx_nxt         = r_tx;
    w_raddr_done_nxt = r_raddr_done;
    w_rx_data_nxt    = r_rx_data;
    w_miso_nxt       = 1'b0;
    w_rx_valid_nxt   = 1'b0;
    w_err_rd_nxt     = 1'b0;
    w_err_tmo_nxt    = 1'b0;

    if (r_state != S_IDLE && ss_n) begin
      // Deselect aborts whatever is in flight; raddr_done survives.
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_tmo_nxt   = '0;
      w_shift_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!ss_n) begin
            w_state_nxt = S_RECV;
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
          end
        end
        S_RECV: begin
          w_shift_nxt = w_frame;
          if (r_cnt == c_RX_LAST) begin
            w_cnt_nxt = '0;
            if (w_cmd != c_CMD_RDATA) begin
              w_rx_data_nxt  = w_frame;
              w_rx_valid_nxt = 1'b1;
              w_state_nxt    = S_HOLD;
              if (w_cmd == c_CMD_RADDR) begin
                w_raddr_done_nxt = 1'b1;
              end
            end else if (r_raddr_done) begin
              w_rx_data_nxt    = w_frame;
              w_rx_valid_nxt   = 1'b1;
              w_raddr_done_nxt = 1'b0;
              w_tmo_nxt        = '0;
              w_state_nxt      = S_WAIT_TX;
            end else begin
              w_err_rd_nxt = 1'b1;
              w_state_nxt  = S_HOLD;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end
        S_WAIT_TX: begin
          // tx_valid is checked first so it wins on the expiry edge.
          if (tx_valid) begin
            w_tx_nxt    = tx_data;
            w_miso_nxt  = tx_data[w_tx_pos];
            w_cnt_nxt   = '0;
            w_tmo_nxt   = '0;
            w_state_nxt = S_SEND;
          end else if (r_tmo == c_TMO_LAST) begin
            w_err_tmo_nxt = 1'b1;
            w_tmo_nxt     = '0;
            w_state_nxt   = S_HOLD;
          end else begin
            w_tmo_nxt = r_tmo + c_TMO_ONE;
          end
        end
        S_SEND: begin
          if (r_cnt == c_TX_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_HOLD;
          end else begin
            w_cnt_nxt  = r_cnt + c_CNT_ONE;
            w_miso_nxt = r_tx[w_tx_pos];
          end
        end
        S_HOLD: begin
          w_state_nxt = S_HOLD;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_tmo_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_tmo        <= '0;
      r_shift      <= '0;
      r_tx         <= '0;
      r_raddr_done <= 1'b0;
      r_miso       <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_err_rd     <= 1'b0;
      r_err_tmo    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tmo        <= w_tmo_nxt;
      r_shift      <= w_shift_nxt;
      r_tx         <= w_tx_nxt;
      r_raddr_done <= w_raddr_done_nxt;
      r_miso       <= w_miso_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_err_rd     <= w_err_rd_nxt;
      r_err_tmo    <= w_err_tmo_nxt;
    end
  end

  assign miso           = r_miso;
  assign rx_data        = r_rx_data;
  assign rx_valid       = r_rx_valid;
  assign err_rd_seq     = r_err_rd;
  assign err_tx_timeout = r_err_tmo;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_ram_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_slave_ram_if                                          |
// | Description : Scoreboard bench for spi_slave_ram_if. Two instances cover   |
// |               8-bit MSB-first and 16-bit LSB-first; only the selected one  |
// |               sees ss_n low. Stimulus pushes expected events, a monitor    |
// |               on the falling edge pops and compares them.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_slave_ram_if;

  localparam int TMO = 16;
  localparam int K_RX = 0, K_ERRSEQ = 1, K_TMO = 2, K_RD = 3;

  typedef struct {
    int          kind;
    logic [17:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = 16'h0;

  int          cfg = 0;
  int          pw  = 8;
  bit          msb = 1'b1;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  bit          model_raddr = 1'b0;

  logic        ss_a, ss_b;
  logic        miso_a, rxv_a, erd_a, eto_a;
  logic [9:0]  rxd_a;
  logic        miso_b, rxv_b, erd_b, eto_b;
  logic [17:0] rxd_b;
  logic        miso_m, rxv_m, erd_m, eto_m;
  logic [17:0] rxd_m;

  assign ss_a   = (cfg == 0) ? ss_n : 1'b1;
  assign ss_b   = (cfg == 1) ? ss_n : 1'b1;
  assign miso_m = (cfg == 0) ? miso_a : miso_b;
  assign rxv_m  = (cfg == 0) ? rxv_a  : rxv_b;
  assign erd_m  = (cfg == 0) ? erd_a  : erd_b;
  assign eto_m  = (cfg == 0) ? eto_a  : eto_b;
  assign rxd_m  = (cfg == 0) ? {8'h00, rxd_a} : rxd_b;

  spi_slave_ram_if #(.PAYLOAD_W(8), .MSB_FIRST(1'b1), .TX_TIMEOUT(TMO)) dut_a (
    .clk(clk), .rst_n(rst_n), .ss_n(ss_a), .mosi(mosi), .miso(miso_a),
    .rx_data(rxd_a), .rx_valid(rxv_a), .tx_data(tx_data[7:0]), .tx_valid(tx_valid),
    .err_rd_seq(erd_a), .err_tx_timeout(eto_a)
  );

  spi_slave_ram_if #(.PAYLOAD_W(16), .MSB_FIRST(1'b0), .TX_TIMEOUT(TMO)) dut_b (
    .clk(clk), .rst_n(rst_n), .ss_n(ss_b), .mosi(mosi), .miso(miso_b),
    .rx_data(rxd_b), .rx_valid(rxv_b), .tx_data(tx_data), .tx_valid(tx_valid),
    .err_rd_seq(erd_b), .err_tx_timeout(eto_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [17:0] got, logic [17:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d, cfg %0d)", name, got, want, cyc, cfg);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  bit          col = 1'b0;
  int          ncol = 0;
  logic [17:0] word;
  logic [4:0]  m_idx;
  int          m_kind;
  exp_t        m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      col = 1'b0;
    end else begin
      if (!col && sb.size() > 0 && sb[0].kind == K_RD && sb[0].cyc == cyc) begin
        col  = 1'b1;
        ncol = 0;
        word = '0;
      end
      if (col) begin
        m_idx       = 5'(msb ? pw - 1 - ncol : ncol);
        word[m_idx] = miso_m;
        ncol++;
        if (ncol == pw) begin
          check("readout_word", word, sb[0].data);
          void'(sb.pop_front());
          col = 1'b0;
        end
      end else begin
        check("miso_idle", 18'(miso_m), 18'd0);
      end
      if (rxv_m || erd_m || eto_m) begin
        m_kind = rxv_m ? K_RX : (erd_m ? K_ERRSEQ : K_TMO);
        check("strobe_onehot", 18'($countones({rxv_m, erd_m, eto_m})), 18'd1);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got kind %0d with rx_data %h, want none (cycle %0d)",
                   m_kind, rxd_m, cyc);
        end else begin
          m_e = sb.pop_front();
          check("event_kind", 18'(m_kind), 18'(m_e.kind));
          check("event_cycle", 18'(cyc), 18'(m_e.cyc));
          if (m_e.kind == K_RX) check("rx_data", rxd_m, m_e.data);
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pmask();
    return 16'((32'd1 << pw) - 1);
  endfunction

  // Select, then shift nbits of the frame in serial order.
  task automatic send_bits(logic [1:0] cmd, logic [15:0] pay, int nbits);
    ss_n = 1'b0;
    tick();
    for (int i = 0; i < nbits; i++) begin
      if (i < 2) mosi = cmd[1'(1 - i)];
      else       mosi = pay[4'(msb ? pw - 1 - (i - 2) : i - 2)];
      tick();
    end
  endtask

  // One frame plus the memory response; lat = cycles after the last bit at
  // which the memory raises tx_valid (only used for a granted read-data).
  task automatic frame(logic [1:0] cmd, logic [15:0] pay_in, int nbits, int lat,
                       logic [15:0] rdata_in);
    int c;
    logic [15:0] pay, rdata;
    pay   = pay_in & pmask();
    rdata = rdata_in & pmask();
    send_bits(cmd, pay, nbits);
    c = cyc;
    if (nbits < pw + 2) begin
      ss_n = 1'b1;
      tick();
      tick();
      return;
    end
    if (cmd != 2'b11) begin
      sb.push_back('{K_RX, (18'(cmd) << pw) | 18'(pay), c});
      if (cmd == 2'b10) model_raddr = 1'b1;
    end else if (!model_raddr) begin
      sb.push_back('{K_ERRSEQ, 18'd0, c});
    end else begin
      sb.push_back('{K_RX, (18'(cmd) << pw) | 18'(pay), c});
      model_raddr = 1'b0;
      if (lat <= TMO) sb.push_back('{K_RD, 18'(rdata), c + lat});
      else            sb.push_back('{K_TMO, 18'd0, c + TMO});
      repeat (lat - 1) tick();
      tx_valid = 1'b1;
      tx_data  = rdata;
      tick();
      tx_valid = 1'b0;
      tx_data  = 16'($urandom);
      repeat (pw) tick();
    end
    repeat (2) begin
      mosi = 1'($urandom);
      tick();
    end
    ss_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic reset_mid_send();
    int c;
    frame(2'b10, 16'h005A, pw + 2, 0, 16'h0);
    send_bits(2'b11, 16'h0000, pw + 2);
    c = cyc;
    sb.push_back('{K_RX, 18'(2'b11) << pw, c});
    model_raddr = 1'b0;
    sb.push_back('{K_RD, 18'(pmask()), c + 2});
    tick();
    tx_valid = 1'b1;
    tx_data  = 16'hFFFF;
    tick();
    tx_valid = 1'b0;
    repeat (3) tick();
    check("miso_bit3_before_reset", 18'(miso_m), 18'd1);
    #1 rst_n = 1'b0;
    #1;
    check("miso_async_reset", 18'(miso_m), 18'd0);
    check("rx_data_async_reset", rxd_m, 18'd0);
    sb.delete();
    ss_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    frame(2'b11, 16'h0000, pw + 2, 1, 16'h0);
  endtask

  task automatic run_suite(int which);
    rst_n    = 1'b0;
    ss_n     = 1'b1;
    tx_valid = 1'b0;
    cfg      = which;
    pw       = (which == 0) ? 8 : 16;
    msb      = (which == 0);
    model_raddr = 1'b0;
    sb.delete();
    tick();
    tick();
    check("reset_miso", 18'(miso_m), 18'd0);
    check("reset_rx_valid", 18'(rxv_m), 18'd0);
    check("reset_rx_data", rxd_m, 18'd0);
    check("reset_err_rd_seq", 18'(erd_m), 18'd0);
    check("reset_err_tx_timeout", 18'(eto_m), 18'd0);
    rst_n = 1'b1;
    tick();

    frame(2'b11, 16'h0000, pw + 2, 1, 16'h0);       // read data without address
    frame(2'b00, 16'h00A5, pw + 2, 0, 16'h0);       // write address
    frame(2'b10, 16'h003C, pw + 2, 0, 16'h0);       // read sequence
    frame(2'b11, 16'h0000, pw + 2, 3, 16'hA4B6);
    frame(2'b11, 16'h0000, pw + 2, 3, 16'h0);       // raddr_done was consumed
    frame(2'b10, 16'h0011, pw + 2, 0, 16'h0);       // timeout
    frame(2'b11, 16'h0000, pw + 2, TMO + 2, 16'h1234);
    frame(2'b10, 16'h0022, pw + 2, 0, 16'h0);       // tx_valid on expiry edge
    frame(2'b11, 16'h0000, pw + 2, TMO, 16'hC35A);
    frame(2'b01, 16'h00FF, 5, 0, 16'h0);            // abort after 5 bits
    frame(2'b01, 16'hFFFF, pw + 2, 0, 16'h0);
    frame(2'b10, 16'h0077, pw + 2, 0, 16'h0);       // raddr_done survives abort
    frame(2'b00, 16'h0001, 4, 0, 16'h0);
    frame(2'b11, 16'h0000, pw + 2, 1, 16'h8001);

    tx_valid = 1'b1;                                 // ignored while idle
    tx_data  = 16'hFFFF;
    repeat (3) tick();
    tx_valid = 1'b0;

    for (int n = 0; n < 40; n++) begin
      int nb;
      nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, pw + 1)) : pw + 2;
      if ($urandom_range(0, 2) == 0) frame(2'b10, 16'($urandom), pw + 2, 0, 16'h0);
      frame(2'($urandom), 16'($urandom), nb, int'($urandom_range(1, TMO + 3)), 16'($urandom));
    end

    reset_mid_send();
    repeat (4) tick();
    check("scoreboard_drained", 18'(sb.size()), 18'd0);
  endtask

  initial begin
    run_suite(0);
    run_suite(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave_ram_if.md
Name: spi_slave_ram_if

Overview:
Parametrised SPI slave bridging a serial master to the single-port data memory over the rx_valid/rx_data and tx_valid/tx_data handshake. One clk edge carries one serial bit. Every frame is a 2-bit command followed by a PAYLOAD_W-bit payload.
Additions over the previous slave:
- configurable payload width and bit order
- full 2-bit command decode at end of frame
- read-sequence checking
- a bounded wait for memory read data, with a timeout
- clean abort on ss_n deassertion

Parameters:
PAYLOAD_W, 8, address/data payload width; must be at least 2. Frame width FRAME_W = PAYLOAD_W+2 is a derived localparam.
MSB_FIRST, 1, 1: payload bits are received and sent MSB first; 0: LSB first. The command is always the first two bits.
TX_TIMEOUT, 16, maximum cycles spent in WAIT_TX before abandoning the read; must be at least 1.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
ss_n  input  1  slave select, active low.
mosi  input  1  serial data in.
miso  output  1  serial data out, registered.
rx_data  output  FRAME_W  {cmd[1:0], payload} handed to memory.
rx_valid  output  1  one-cycle strobe qualifying rx_data.
tx_data  input  PAYLOAD_W  read data from memory.
tx_valid  input  1  qualifies tx_data.
err_rd_seq  output  1  one-cycle pulse: read-data command received with no preceding read-address.
err_tx_timeout  output  1  one-cycle pulse: memory did not answer within TX_TIMEOUT cycles.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; bit counter, timeout counter and shift registers cleared.
  - raddr_done=0; miso=0; rx_data=0; rx_valid=0; both err outputs 0.
- Commands (first two bits): 00 write address, 01 write data, 10 read address, 11 read data.
- States: IDLE, RECV, WAIT_TX, SEND, HOLD.
- IDLE:
  - ss_n=0 sampled → RECV.
  - mosi is not sampled on that edge.
- RECV:
  - mosi is shifted in on each edge: FRAME_W edges, counter 0..FRAME_W-1.
  - Command bits fill rx_data[FRAME_W-1:FRAME_W-2], first bit received = bit FRAME_W-1.
  - Payload fills bits [PAYLOAD_W-1:0]: MSB down when MSB_FIRST=1, bit 0 up when MSB_FIRST=0.
- On the edge sampling the last bit:
  - cmd 00/01/10 → register rx_data, rx_valid=1 for exactly the next cycle, go to HOLD. cmd 10 also sets raddr_done.
  - cmd 11 with raddr_done=1 → rx_data/rx_valid as above, clear raddr_done, go to WAIT_TX, timeout counter=0.
  - cmd 11 with raddr_done=0 → no rx_valid, err_rd_seq=1 for one cycle, go to HOLD.
- WAIT_TX:
  - tx_valid=1 → capture tx_data, go to SEND, and drive the first payload bit on miso from the next cycle.
  - Otherwise the counter increments; when it reaches TX_TIMEOUT, err_tx_timeout pulses one cycle and the FSM goes to HOLD.
  - tx_valid on the expiry edge wins: the data is captured and no error is raised.
- SEND:
  - miso presents the PAYLOAD_W bits on consecutive cycles, one bit per cycle, in MSB_FIRST order.
  - After the last bit, miso=0 and the FSM goes to HOLD.
- HOLD: extra mosi bits are ignored; the FSM waits for ss_n=1.
- ss_n=1 sampled in any non-IDLE state → IDLE next cycle:
  - partial frame discarded; no rx_valid, no error pulse.
  - miso=0; counters cleared.
  - raddr_done retained.
- rx_valid and the err pulses never assert in the same cycle.
- tx_valid outside WAIT_TX is ignored.
- miso=0 in every state other than SEND.
- rx_data holds its last value between strobes.

Test Plan:
- Write address: ss_n low, mosi 0,0,1,0,1,0,0,1,0,1 (PAYLOAD_W=8, MSB_FIRST=1) → rx_data=10'h0A5, rx_valid high one cycle, the cycle after the 10th sampled bit; then ss_n high → IDLE.
- Read sequence: frame cmd 10 payload 8'h3C, then frame cmd 11 payload 8'h00; memory returns tx_valid with tx_data=8'hB6 3 cycles after the second rx_valid → miso shows 1,0,1,1,0,1,1,0 over 8 consecutive cycles starting the cycle after capture, then 0; raddr_done cleared.
- Read data without a prior read address, straight after reset: frame cmd 11 → no rx_valid, err_rd_seq one-cycle pulse, miso stays 0.
- Timeout: valid read-address then read-data frames, tx_valid held 0 → err_tx_timeout pulses 16 cycles after entry to WAIT_TX, miso stays 0. Repeat with tx_valid on the expiry cycle → data sent, no error.
- Abort: raise ss_n after 5 bits of a write-data frame → no rx_valid. The next full frame cmd 01 payload 8'hFF → rx_data=10'h1FF.
- Reset mid-SEND: assert rst_n=0 during bit 3 of miso → miso=0, state IDLE immediately. Repeat the suite with MSB_FIRST=0 and PAYLOAD_W=16 → bit order reversed, 18-bit frames.
